// File: rtl/imm_li_expander.sv
// imm_li_expander: expands a 32-bit constant into the RV32I li sequence (ADDI, or LUI + optional ADDI).
// Optional build macro LI_ZERO_RD_DROP_EN: requests targeting x0 are accepted and silently discarded.
module imm_li_expander (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] value_i,
    input  logic [4:0]  rd_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        last_o
);
    typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B} state_t;

    state_t      state, state_d;
    logic [31:0] pend, pend_d, instr_d;
    logic        last_d, valid_d;
    logic        fits, drop;
    logic [19:0] upper;
    logic [11:0] low;
    logic [31:0] addi_x0, addi_rd, lui;

    assign fits    = (&value_i[31:11]) | ~(|value_i[31:11]);
    // Rounding up by bit 11 compensates for the sign-extended low ADDI; wraps mod 2^20 by design.
    assign upper   = value_i[31:12] + {19'd0, value_i[11]};
    assign low     = value_i[11:0];
    assign addi_x0 = {low, 5'd0, 3'b000, rd_i, 7'b0010011};
    assign addi_rd = {low, rd_i, 3'b000, rd_i, 7'b0010011};
    assign lui     = {upper, rd_i, 7'b0110111};
    assign req_ready_o = (state == IDLE);

`ifdef LI_ZERO_RD_DROP_EN
    assign drop = (rd_i == 5'd0);
`else
    assign drop = 1'b0;
`endif

    // State and registered instruction outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            instr_o       <= '0;
            last_o        <= 1'b0;
            instr_valid_o <= 1'b0;
            pend          <= '0;
        end else begin
            state         <= state_d;
            instr_o       <= instr_d;
            last_o        <= last_d;
            instr_valid_o <= valid_d;
            pend          <= pend_d;
        end
    end

    // Next state: accept in IDLE, advance on each output handshake.
    always_comb begin
        state_d = state;
        instr_d = instr_o;
        last_d  = last_o;
        valid_d = instr_valid_o;
        pend_d  = pend;
        case (state)
            IDLE: begin
                if (req_valid_i && !drop) begin
                    state_d = EMIT_A;
                    valid_d = 1'b1;
                    instr_d = fits ? addi_x0 : lui;
                    last_d  = fits || (low == 12'd0);
                    pend_d  = addi_rd;
                end
            end
            EMIT_A: begin
                if (instr_ready_i) begin
                    state_d = last_o ? IDLE : EMIT_B;
                    valid_d = !last_o;
                    instr_d = last_o ? instr_o : pend;
                    last_d  = 1'b1;
                end
            end
            EMIT_B: begin
                if (instr_ready_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_imm_li_expander.sv
// tb_imm_li_expander: directed vectors, stall/reset sequences and randomized checks against an li reference model.
module tb_imm_li_expander;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] value_i = '0;
    logic [4:0]  rd_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic        last_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] value;
        logic [4:0]  rd;
        int          n;
        logic [31:0] i0;
        logic [31:0] i1;
    } vec_t;

    vec_t vecs[$];

    imm_li_expander dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .value_i(value_i), .rd_i(rd_i), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .last_o(last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    // li semantics: small signed constants take one ADDI; otherwise LUI of the rounded upper part plus ADDI of the low part.
    task automatic model(input logic [31:0] v, input logic [4:0] rd, output int n, output logic [31:0] e0, output logic [31:0] e1);
        int          sv;
        logic [31:0] rounded;
        sv = $signed(v);
        e1 = '0;
        if (sv >= -2048 && sv <= 2047) begin
            n  = 1;
            e0 = enc_addi(v[11:0], 5'd0, rd);
        end else begin
            rounded = v + 32'h800;
            e0 = enc_lui(rounded[31:12], rd);
            n  = (v[11:0] == 12'd0) ? 1 : 2;
            e1 = enc_addi(v[11:0], rd, rd);
        end
    endtask

    task automatic send(input logic [31:0] v, input logic [4:0] rd);
        chk("req_ready_before_accept", {31'd0, req_ready_o}, 32'd1);
        value_i = v;
        rd_i = rd;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic collect(input int n, input logic [31:0] e0, input logic [31:0] e1, input int stall_pct);
        for (int k = 0; k < n; k++) begin
            logic [31:0] exp_i;
            int          cyc;
            bit          done;
            exp_i = (k == 0) ? e0 : e1;
            cyc = 0;
            done = 0;
            while (!done) begin
                instr_ready_i = (cyc >= 10) || ($urandom_range(0, 99) >= stall_pct);
                chk("instr_valid", {31'd0, instr_valid_o}, 32'd1);
                chk("instr", instr_o, exp_i);
                chk("last", {31'd0, last_o}, {31'd0, (k == n - 1)});
                chk("req_ready_busy", {31'd0, req_ready_o}, 32'd0);
                done = instr_ready_i;
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        instr_ready_i = 1'b1;
        chk("valid_after_seq", {31'd0, instr_valid_o}, 32'd0);
        chk("req_ready_after_seq", {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        int          n;
        logic [31:0] e0, e1, v;
        logic [4:0]  rd;

        vecs.push_back('{32'h0000_07FF, 5'd5,  1, 32'h7FF0_0293, 32'h0});
        vecs.push_back('{32'hFFFF_F800, 5'd1,  1, 32'h8000_0093, 32'h0});
        vecs.push_back('{32'h0000_0800, 5'd10, 2, 32'h0000_1537, 32'h8005_0513});
        vecs.push_back('{32'h1234_5000, 5'd3,  1, 32'h1234_51B7, 32'h0});
        vecs.push_back('{32'h7FFF_FFFF, 5'd3,  2, 32'h8000_01B7, 32'hFFF1_8193});
        vecs.push_back('{32'h0000_0000, 5'd7,  1, 32'h0000_0393, 32'h0});
        vecs.push_back('{32'hFFFF_F7FF, 5'd2,  2, 32'hFFFF_F137, 32'h7FF1_0113});
`ifndef LI_ZERO_RD_DROP_EN
        vecs.push_back('{32'h0000_0005, 5'd0,  1, 32'h0050_0013, 32'h0});
`endif

        #2;
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_last", {31'd0, last_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        foreach (vecs[i]) begin
            send(vecs[i].value, vecs[i].rd);
            collect(vecs[i].n, vecs[i].i0, vecs[i].i1, 0);
        end

        instr_ready_i = 1'b0;
        send(32'h7FFF_FFFF, 5'd3);
        value_i = 32'h0000_0001;
        rd_i = 5'd9;
        req_valid_i = 1'b1;
        repeat (3) begin
            chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("stall_instr", instr_o, 32'h8000_01B7);
            chk("stall_last", {31'd0, last_o}, 32'd0);
            chk("stall_req_ready", {31'd0, req_ready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
        collect(2, 32'h8000_01B7, 32'hFFF1_8193, 0);

        instr_ready_i = 1'b0;
        send(32'h0000_0800, 5'd10);
        chk("pre_reset_instr", instr_o, 32'h0000_1537);
        #2 rst_n_i = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("async_rst_instr", instr_o, 32'd0);
        chk("async_rst_last", {31'd0, last_o}, 32'd0);
        chk("async_rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        #1 rst_n_i = 1'b1;
        instr_ready_i = 1'b1;
        repeat (4) begin
            @(posedge clk_i); #1;
            chk("no_pending_after_rst", {31'd0, instr_valid_o}, 32'd0);
            chk("idle_after_rst", {31'd0, req_ready_o}, 32'd1);
        end

`ifdef LI_ZERO_RD_DROP_EN
        send(32'h0000_0005, 5'd0);
        repeat (3) begin
            chk("drop_valid", {31'd0, instr_valid_o}, 32'd0);
            chk("drop_req_ready", {31'd0, req_ready_o}, 32'd1);
            @(posedge clk_i); #1;
        end
`endif

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: v = 32'($signed($urandom_range(0, 4095)) - 2048);
                1: v = {$urandom(), 12'h000} ;
                2: v = 32'($signed($urandom_range(0, 63)) - 32 + (($urandom_range(0, 1) == 1) ? 2047 : -2048));
                default: v = $urandom();
            endcase
            rd = 5'($urandom_range(1, 31));
            model(v, rd, n, e0, e1);
            send(v, rd);
            collect(n, e0, e1, 40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
